imm_decode_ctrl: RTL and testbench

//   Decode-stage controller for immediate generation in the 16-bit core. Accepts one instruction per

---
 rtl/imm_decode_ctrl.sv | 133 +++++++++++++
 tb/tb_imm_decode_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage immediate generator with valid/ready handshake, stall and flush
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    instruction handshake; in_instr is the 16-bit instruction word
//   flush                discards every held or in-flight entry (branch redirect)
//   out_valid/out_ready  entry handshake towards execute
//   out_imm              extended immediate
//   out_class            00 none, 01 imm5, 10 imm8, 11 imm11
//   out_zext             immediate was zero-extended
// Option IMM_SKID_BUF_EN: registered in_ready plus a 1-entry skid buffer; otherwise a single
// output register with in_ready = !out_valid || out_ready.
module imm_decode_ctrl #(
  parameter int OPC_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [1:0]        out_class,
  output logic              out_zext
);
  localparam int ENT_W = DATA_W + 3;
  logic [OPC_W-1:0]  opc;
  logic [1:0]        dec_class;
  logic              dec_zext;
  logic [1:0]        sx_mode;
  logic [DATA_W-1:0] sx_field;
  logic [DATA_W-1:0] dec_imm;
  logic [ENT_W-1:0]  dec_ent;
  logic [ENT_W-1:0]  out_ent_d, out_ent_q;
  logic              accept;
  always_comb begin
    opc = in_instr[DATA_W-1 -: OPC_W];
    case (opc)
      5'b01000, 5'b01001, 5'b10100, 5'b10101, 5'b10110,
      5'b10111, 5'b10000, 5'b10001, 5'b10011:          {dec_class, dec_zext} = 3'b010;
      5'b01010, 5'b01011:                              {dec_class, dec_zext} = 3'b011;
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b11000, 5'b00101, 5'b00111:                    {dec_class, dec_zext} = 3'b100;
      5'b10010:                                        {dec_class, dec_zext} = 3'b101;
      5'b00100, 5'b00110:                              {dec_class, dec_zext} = 3'b110;
      default:                                         {dec_class, dec_zext} = 3'b000;
    endcase
    // Zero-extended forms run the extender in pass-through mode on a pre-masked field,
    // so the upper bits are guaranteed zero.
    sx_mode  = dec_zext ? 2'b00 : dec_class;
    sx_field = dec_class == 2'b00 ? '0 :
               !dec_zext          ? in_instr :
               dec_class == 2'b01 ? {{(DATA_W-5){1'b0}}, in_instr[4:0]} :
                                    {{(DATA_W-8){1'b0}}, in_instr[7:0]};
    dec_imm  = sx_mode == 2'b01 ? {{(DATA_W-5){sx_field[4]}},  sx_field[4:0]}  :
               sx_mode == 2'b10 ? {{(DATA_W-8){sx_field[7]}},  sx_field[7:0]}  :
               sx_mode == 2'b11 ? {{(DATA_W-11){sx_field[10]}}, sx_field[10:0]} :
                                  sx_field;
    dec_ent  = {dec_imm, dec_class, dec_zext};
  end
  assign accept    = in_valid && in_ready;
  assign out_imm   = out_ent_q[ENT_W-1:3];
  assign out_class = out_ent_q[2:1];
  assign out_zext  = out_ent_q[0];
`ifdef IMM_SKID_BUF_EN
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;
  logic [1:0]       state_d, state_q;
  logic [ENT_W-1:0] skid_ent_d, skid_ent_q;
  logic             in_ready_d, in_ready_q;
  always_comb begin
    state_d    = state_q;
    out_ent_d  = out_ent_q;
    skid_ent_d = skid_ent_q;
    if (flush)
      state_d = S_EMPTY;
    else
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d   = S_ONE;
          out_ent_d = dec_ent;
        end
        S_ONE: if (accept && out_ready)
          out_ent_d = dec_ent;
        else if (accept) begin
          // accept landed in a stall cycle: park it in the skid entry
          state_d    = S_TWO;
          skid_ent_d = dec_ent;
        end else if (out_ready)
          state_d = S_EMPTY;
        S_TWO: if (out_ready) begin
          state_d   = S_ONE;
          out_ent_d = skid_ent_q;
        end
        default: state_d = S_EMPTY;
      endcase
    in_ready_d = state_d != S_TWO;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      out_ent_q  <= '0;
      skid_ent_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_ent_q  <= out_ent_d;
      skid_ent_q <= skid_ent_d;
      in_ready_q <= in_ready_d;
    end
  assign in_ready  = in_ready_q;
  assign out_valid = state_q != S_EMPTY;
`else
  logic out_valid_d, out_valid_q;
  always_comb begin
    out_valid_d = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_ent_d   = (accept && !flush) ? dec_ent : out_ent_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ent_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ent_q   <= out_ent_d;
    end
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
`endif
endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: scoreboard bench with a reference decode model and randomized traffic
module tb_imm_decode_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_imm;
  logic [1:0]  out_class;
  logic        out_zext;
  logic [18:0] q[$];
  int          vecs = 0;
  int          errs = 0;
  imm_decode_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_class(out_class), .out_zext(out_zext)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [18:0] model(input logic [15:0] ins);
    int op, v;
    logic [1:0] c;
    logic z;
    op = int'(ins[15:11]);
    c = 2'd0; z = 1'b0; v = 0;
    if (op inside {8, 9, 20, 21, 22, 23, 16, 17, 19}) begin
      c = 2'd1; v = int'(ins[4:0]); if (v > 15) v -= 32;
    end else if (op inside {10, 11}) begin
      c = 2'd1; z = 1'b1; v = int'(ins[4:0]);
    end else if (op inside {12, 13, 14, 15, 24, 5, 7}) begin
      c = 2'd2; v = int'(ins[7:0]); if (v > 127) v -= 256;
    end else if (op == 18) begin
      c = 2'd2; z = 1'b1; v = int'(ins[7:0]);
    end else if (op inside {4, 6}) begin
      c = 2'd3; v = int'(ins[10:0]); if (v > 1023) v -= 2048;
    end
    return {v[15:0], c, z};
  endfunction
  // Monitor: every cycle an entry is presented it must equal the oldest outstanding expectation.
  always @(negedge clk)
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL spurious_entry actual imm=%h class=%b required no entry", out_imm, out_class);
      end else begin
        chk("entry", {13'd0, out_imm, out_class, out_zext}, {13'd0, q[0]});
        if (out_ready) void'(q.pop_front());
      end
    end
  // Driver: one cycle per call; records the expectation once the handshake outcome is known.
  task automatic step(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl;
    @(negedge clk);
    #1;
    if (fl) q.delete();
    else if (in_valid && in_ready) q.push_back(model(ins));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
  endtask
  initial begin
    logic [15:0] stream[8];
    logic [15:0] r;
    #2;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_imm", {16'd0, out_imm}, 32'd0);
    chk("reset_class", {30'd0, out_class}, 32'd0);
    chk("reset_zext", {31'd0, out_zext}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // asynchronous reset in the middle of a transfer
    step(1'b1, 16'h4003, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_imm", {16'd0, out_imm}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // directed decode cases
    step(1'b1, 16'h401F, 1'b1, 1'b0);
    step(1'b1, 16'h501F, 1'b1, 1'b0);
    step(1'b1, 16'h90F0, 1'b1, 1'b0);
    step(1'b1, 16'h6080, 1'b1, 1'b0);
    step(1'b1, 16'h2400, 1'b1, 1'b0);
    idle(3);
    chk("model_addi", {13'd0, model(16'h401F)}, {13'd0, 16'hFFFF, 2'b01, 1'b0});
    chk("model_xori", {13'd0, model(16'h501F)}, {13'd0, 16'h001F, 2'b01, 1'b1});
    chk("model_j", {13'd0, model(16'h2400)}, {13'd0, 16'hFC00, 2'b11, 1'b0});
    // three-cycle stall with in_valid held
    step(1'b1, 16'h4011, 1'b1, 1'b0);
    step(1'b1, 16'h6555, 1'b0, 1'b0);
`ifdef IMM_SKID_BUF_EN
    chk("stall1_ready", {31'd0, in_ready}, 32'd1);
`else
    chk("stall1_ready", {31'd0, in_ready}, 32'd0);
`endif
    step(1'b1, 16'h6555, 1'b0, 1'b0);
    chk("stall2_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 16'h6555, 1'b0, 1'b0);
    chk("stall3_ready", {31'd0, in_ready}, 32'd0);
    idle(4);
    chk("stall_drain", q.size(), 32'd0);
    // flush while output (and skid, if present) is full and a new instruction is offered
    step(1'b1, 16'h4001, 1'b1, 1'b0);
    step(1'b1, 16'h4802, 1'b0, 1'b0);
    step(1'b1, 16'hC0AA, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    idle(2);
    // back-to-back stream with execute always ready
    stream = '{16'h0000, 16'h4005, 16'h5015, 16'h9001, 16'h6880, 16'h3555, 16'hC07F, 16'hF800};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, stream[i], 1'b1, 1'b0);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    idle(2);
    chk("stream_drain", q.size(), 32'd0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      step(($urandom % 4) != 0, r, ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    idle(1);
    chk("final_drain", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
